// File: rtl/shift_arbiter.sv
// shift_arbiter: time-shares one combinational barrel shifter between two
// requesters. Round-robin arbitration in IDLE, a registered shift in EXEC and
// a held response in RESP until the consumer takes it.
// Optional build macro SHIFT_LONG_EN: widens shamt to M+1 bits. When the top
// bit is set, a second pass (EXEC2) lets the result saturate.
module shift_arbiter #(
    parameter int N = 32,
    parameter int M = 5,
`ifdef SHIFT_LONG_EN
    localparam int SW = M + 1
`else
    localparam int SW = M
`endif
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [N-1:0]  req0_data,
    input  logic [SW-1:0] req0_shamt,
    input  logic          req0_dir,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [N-1:0]  req1_data,
    input  logic [SW-1:0] req1_shamt,
    input  logic          req1_dir,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [N-1:0]  rsp_data,
    output logic          busy
);

`ifdef SHIFT_LONG_EN
    typedef enum logic [1:0] {IDLE, EXEC, RESP, EXEC2} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    state_t        state_reg;
    logic          last_grant_reg;
    logic [N-1:0]  op_data_reg;
    logic [SW-1:0] op_shamt_reg;
    logic          op_dir_reg;
    logic          op_id_reg;
    logic          rsp_valid_reg;
    logic          rsp_id_reg;
    logic [N-1:0]  rsp_data_reg;
`ifdef SHIFT_LONG_EN
    logic [N-1:0]  long_reg;
`endif

    // Shifter operands
    logic [N-1:0]  sh_in;
    logic [M-1:0]  sh_amt;
    logic          sh_dir;
    logic [N-1:0]  sh_out;

    // Arbitration: only offered in IDLE. On a tie, the requester that did not
    // win last time is granted. Reset masks the readies.
    logic idle;
    logic grant0;
    logic grant1;

    assign idle   = (state_reg == IDLE) && !reset;
    assign grant0 = idle && req0_valid && (!req1_valid || last_grant_reg);
    assign grant1 = idle && req1_valid && !grant0;

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_data   = rsp_data_reg;
    assign busy       = (state_reg != IDLE);

    // Shifter input select. A long shift is two passes: by 2**M-1 from the
    // operand, then by 1 from the intermediate register.
`ifdef SHIFT_LONG_EN
    assign sh_in  = (state_reg == EXEC2) ? long_reg : op_data_reg;
    assign sh_amt = (state_reg == EXEC2) ? M'(1) :
                    (op_shamt_reg[M] ? {M{1'b1}} : op_shamt_reg[M-1:0]);
`else
    assign sh_in  = op_data_reg;
    assign sh_amt = op_shamt_reg;
`endif
    assign sh_dir = op_dir_reg;

    // Log-depth barrel shifter. Stage gi shifts by 2**gi when sh_amt[gi] is set.
    for (genvar gi = 0; gi < M; gi++) begin : g_stage
        logic        [N-1:0] s_in;
        logic        [N-1:0] s_out;
        logic signed [N-1:0] s_sgn;
        logic        [N-1:0] s_asr;
        logic        [N-1:0] s_shl;

        if (gi == 0) begin : g_first
            assign s_in = sh_in;
        end else begin : g_next
            assign s_in = g_stage[gi-1].s_out;
        end

        assign s_sgn = s_in;
        assign s_asr = s_sgn >>> (2 ** gi);
        assign s_shl = s_in << (2 ** gi);
        assign s_out = !sh_amt[gi] ? s_in : (sh_dir ? s_asr : s_shl);
    end

    assign sh_out = g_stage[M-1].s_out;

    // Sequencing FSM: latch on grant, shift, then hold the response until it is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_data_reg    <= '0;
            op_shamt_reg   <= '0;
            op_dir_reg     <= 1'b0;
            op_id_reg      <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_data_reg   <= '0;
`ifdef SHIFT_LONG_EN
            long_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_data_reg    <= grant1 ? req1_data  : req0_data;
                        op_shamt_reg   <= grant1 ? req1_shamt : req0_shamt;
                        op_dir_reg     <= grant1 ? req1_dir   : req0_dir;
                        op_id_reg      <= grant1;
                        last_grant_reg <= grant1;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_id_reg <= op_id_reg;
`ifdef SHIFT_LONG_EN
                    if (op_shamt_reg[M]) begin
                        long_reg  <= sh_out;
                        state_reg <= EXEC2;
                    end else begin
                        rsp_data_reg  <= sh_out;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
`else
                    rsp_data_reg  <= sh_out;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
`endif
                end
`ifdef SHIFT_LONG_EN
                EXEC2: begin
                    rsp_data_reg  <= sh_out;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: directed cases plus random traffic. Accepted
// requests push expected responses into a scoreboard. A separate monitor
// checks the responses against that scoreboard.
module tb_shift_arbiter;
    localparam int N = 32;
    localparam int M = 5;
`ifdef SHIFT_LONG_EN
    localparam int SW = M + 1;
`else
    localparam int SW = M;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          v   [2];
    logic          rdy [2];
    logic [N-1:0]  d   [2];
    logic [SW-1:0] s   [2];
    logic          r   [2];
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [N-1:0]  rsp_data;
    logic          busy;

    always #5 clock = ~clock;

    shift_arbiter #(.N(N), .M(M)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (v[0]),
        .req0_ready (rdy[0]),
        .req0_data  (d[0]),
        .req0_shamt (s[0]),
        .req0_dir   (r[0]),
        .req1_valid (v[1]),
        .req1_ready (rdy[1]),
        .req1_data  (d[1]),
        .req1_shamt (s[1]),
        .req1_dir   (r[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    typedef struct {
        logic         id;
        logic [N-1:0] data;
        int           vcyc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   model_last = 1'b1;
    bit   acc [2];
    bit   prev_acc = 1'b0;

    always @(posedge clock) cyc++;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference shift over the full amount. Any amount >= N saturates:
    // zeros for a left shift, copies of the sign bit for an arithmetic right shift.
    function automatic logic [N-1:0] ref_shift(logic [N-1:0] x, int amt, bit dir);
        logic [2*N-1:0] t;
        longint         sx;
        if (!dir) begin
            t = {{N{1'b0}}, x} << amt;
            return t[N-1:0];
        end
        sx = {{(64-N){x[N-1]}}, x};
        sx = sx >>> amt;
        return sx[N-1:0];
    endfunction

    // One clock of stimulus: check arbitration at the falling edge, then drop
    // any accepted valid just after the rising edge.
    task automatic tick();
        bit e0;
        bit e1;
        int lat;
        exp_t e;
        @(negedge clock);
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (!reset) begin
            if (prev_acc) check("busy_exec", busy, 1);
            prev_acc = 1'b0;
            check("ready_onehot", rdy[0] & rdy[1], 0);
            if (busy) begin
                check("ready_busy", {rdy[0], rdy[1]}, 0);
            end else begin
                if (v[0] && v[1]) begin
                    e0 = model_last;
                    e1 = !model_last;
                end else begin
                    e0 = v[0];
                    e1 = v[1];
                end
                check("grant", {rdy[0], rdy[1]}, {e0, e1});
            end
            for (int i = 0; i < 2; i++) begin
                if (v[i] && rdy[i]) begin
                    acc[i] = 1'b1;
                    prev_acc = 1'b1;
                    model_last = bit'(i);
                    grant_log.push_back(i);
                    lat = 2;
`ifdef SHIFT_LONG_EN
                    if (s[i][M]) lat = 3;
`endif
                    e.id   = 1'(i);
                    e.data = ref_shift(d[i], int'(s[i]), r[i]);
                    e.vcyc = cyc + lat;
                    sb.push_back(e);
                    $display("[TB] accept req%0d data=%h shamt=%0d dir=%0d", i, d[i], s[i], r[i]);
                end
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) if (acc[i]) v[i] = 1'b0;
    endtask

    task automatic issue(int i, logic [N-1:0] dd, logic [SW-1:0] ss, bit dr);
        v[i] = 1'b1;
        d[i] = dd;
        s[i] = ss;
        r[i] = dr;
    endtask

    task automatic wait_accept(int i);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!acc[i] && n < 60);
        check("accept_timeout", acc[i], 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // Response monitor: pops the scoreboard on each handshake and checks
    // latency, content, stability while stalled and the drop afterwards.
    logic         prev_valid = 1'b0;
    logic         after_hs = 1'b0;
    logic         held_id = 1'b0;
    logic [N-1:0] held_data = '0;

    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
            after_hs = 1'b0;
        end else begin
            if (after_hs) begin
                check("valid_drop", rsp_valid, 0);
                check("busy_idle", busy, 0);
            end
            after_hs = 1'b0;
            if (rsp_valid) begin
                check("busy_resp", busy, 1);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL spurious_rsp: got id=%0d data=%h, required no response", rsp_id, rsp_data);
                    end else begin
                        check("rsp_id", rsp_id, sb[0].id);
                        check("rsp_data", rsp_data, sb[0].data);
                        check("latency", cyc, sb[0].vcyc);
                        $display("[TB] response id=%0d data=%h", rsp_id, rsp_data);
                    end
                    held_id = rsp_id;
                    held_data = rsp_data;
                end else begin
                    check("stable_id", rsp_id, held_id);
                    check("stable_data", rsp_data, held_data);
                end
                if (rsp_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    after_hs = 1'b1;
                end
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
            s[i] = '0;
            r[i] = 1'b0;
        end
        acc[0] = 1'b0;
        acc[1] = 1'b0;

        // Reset state: readies stay low even with both valids high during reset
        repeat (3) @(posedge clock);
        #1;
        v[0] = 1'b1;
        v[1] = 1'b1;
        @(negedge clock);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_readies", {rdy[0], rdy[1]}, 0);
        @(posedge clock);
        #1;
        v[0] = 1'b0;
        v[1] = 1'b0;
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Single requests on each side
        issue(0, 32'h0000_00F0, SW'(4), 1'b0);
        wait_accept(0);
        drain();
        issue(1, 32'h8000_0010, SW'(4), 1'b1);
        wait_accept(1);
        drain();

        // Both requesters always valid: grants must alternate 0,1,0,1
        grant_log.delete();
        issue(0, $urandom, SW'($urandom), 1'($urandom));
        issue(1, $urandom, SW'($urandom), 1'($urandom));
        n = 0;
        while (grant_log.size() < 4 && n < 60) begin
            tick();
            n++;
            for (int i = 0; i < 2; i++)
                if (acc[i]) issue(i, $urandom, SW'($urandom), 1'($urandom));
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        check("fair_count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check("fair_order", grant_log[k], k % 2);
        drain();

        // Response stalled for several cycles with req1 waiting
        rsp_ready = 1'b0;
        issue(0, $urandom, SW'($urandom), 1'($urandom));
        wait_accept(0);
        issue(1, $urandom, SW'($urandom), 1'($urandom));
        repeat (7) tick();
        rsp_ready = 1'b1;
        wait_accept(1);
        drain();

        // Reset during EXEC discards the operation and restores tie priority to req0
        issue(1, 32'h1234_5678, SW'(3), 1'b0);
        wait_accept(1);
        reset = 1'b1;
        sb.delete();
        prev_acc = 1'b0;
        model_last = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_data", rsp_data, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clock);
        #1;
        issue(0, 32'hA5A5_0F0F, SW'(8), 1'b1);
        issue(1, 32'h0F0F_A5A5, SW'(8), 1'b0);
        wait_accept(0);
        wait_accept(1);
        drain();

`ifdef SHIFT_LONG_EN
        // Long shifts saturate
        issue(0, 32'h8000_0000, SW'(40), 1'b1);
        wait_accept(0);
        drain();
        issue(1, 32'hFFFF_FFFF, SW'(40), 1'b0);
        wait_accept(1);
        drain();
`endif

        // Random traffic with random response back-pressure
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++)
                if (!v[i] && $urandom_range(0, 2) == 0)
                    issue(i, $urandom, SW'($urandom), 1'($urandom));
            tick();
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        rsp_ready = 1'b1;
        drain();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Sequencing controller that time-shares one combinational barrel shifter (N-bit data, M-bit shift amount) between two requesters.
- Contains the shifter instance, a round-robin arbiter, operand/result registers and a small FSM.
- Sits beside the ALU; callers hand off shift operations with valid/ready and get a tagged, registered result back.

Parameters:
- N, 32, data width
- M, 5, shift-amount width; the shifter covers 0..2**M-1

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_data  input  N  operand
- req0_shamt  input  M (M+1 with SHIFT_LONG_EN)  shift amount
- req0_dir  input  1  0 = logical left, 1 = arithmetic right
- req1_valid, req1_ready, req1_data, req1_shamt, req1_dir: same as requester 0
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that issued the result
- rsp_data  output  N  shifted result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous, active-high, on clock and reset only.
- Reset values: state=IDLE; rsp_valid=0; rsp_id=0; rsp_data=0; busy=0; both readies 0; last_grant=1, so req0 wins the first tie.
- Reset asserted mid-operation discards the operation. No response is produced.
- FSM states: IDLE, EXEC, RESP (plus EXEC2 with SHIFT_LONG_EN).
- IDLE, arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - Grant: reqX_ready=1 combinationally in that same cycle. data, shamt, dir and id are latched; last_grant is updated; next state is EXEC.
  - Ready is never asserted outside IDLE. The readies are one-hot or zero.
- EXEC:
  - Shifter is driven from the latched registers; its output is registered into rsp_data; rsp_id is set.
  - Next state is RESP with rsp_valid=1.
- RESP:
  - rsp_valid, rsp_id and rsp_data stay stable until rsp_ready=1.
  - On the handshake cycle, rsp_valid drops at the next edge and the state returns to IDLE.
- Latency: accepted at edge T gives rsp_valid high after edge T+2. rsp_ready held high gives one op per 3 cycles.
- Requests that arrive while busy wait; valid must be held by the requester. Fairness: with both requesters always valid, grants alternate 0,1,0,1.
- Shift semantics:
  - shamt=0 passes data through unchanged.
  - Left shift fills with 0.
  - Arithmetic right fills with data[N-1].
- Simultaneous rsp_ready in RESP and new valids: the new grant occurs in the following IDLE cycle, not in RESP.

Optional Feature:
- Macro: SHIFT_LONG_EN.
- Defined:
  - shamt ports are M+1 bits.
  - If shamt[M]=0, behaviour is identical to undefined.
  - If shamt[M]=1, EXEC shifts by 2**M-1 into an internal register, then EXEC2 shifts that value by 1 in the same direction and registers it into rsp_data.
  - Result saturates: left gives all zeros, arithmetic right gives all sign bits. Latency is T+3.
- Undefined: shamt is M bits, EXEC2 does not exist, and latency is always T+2.

Test Plan:
- Reset, then req0: data=0x0000_00F0, shamt=4, dir=0 -> req0_ready pulse; rsp_valid after 2 cycles; rsp_data=0x0000_0F00, rsp_id=0.
- req1: data=0x8000_0010, shamt=4, dir=1 -> rsp_data=0xF800_0001, rsp_id=1.
- Both valid continuously, rsp_ready=1, 4 ops -> grant order 0,1,0,1; readies never both high; busy low only in IDLE cycles.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; no ready asserted. The pending req1 is accepted only after the response handshake.
- Reset pulsed in EXEC -> next cycle state IDLE, rsp_valid=0, rsp_data=0; the next tie is granted to req0.
- SHIFT_LONG_EN, shamt=40: data=0x8000_0000, dir=1 -> 0xFFFF_FFFF at T+3. dir=0 with data=0xFFFF_FFFF -> 0x0000_0000.
